// File: rtl/timer_irq_pkg.sv
// Shared definitions for the timer interrupt controller: register map, FSM states,
// channel count and id width.
package timer_irq_pkg;

  localparam int NCH_DEFAULT = 4;
  localparam int ID_W        = 2;

  localparam logic [7:0] ADDR_IPR = 8'h00;
  localparam logic [7:0] ADDR_IMR = 8'h01;
  localparam logic [7:0] ADDR_ISR = 8'h02;
  localparam logic [7:0] ADDR_ICR = 8'h03;
  localparam logic [7:0] ADDR_EOI = 8'h04;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } state_e;

  // The register map is contiguous from 0x00 up to EOI.
  function automatic logic addr_mapped(input logic [7:0] addr);
    return (addr <= ADDR_EOI);
  endfunction

endpackage

// File: rtl/timer_irq_ctrl_if.sv
// APB slave bus bundle for the timer interrupt controller (8-bit address/data).
interface timer_irq_ctrl_if;
  logic       psel;
  logic       penable;
  logic       pwrite;
  logic [7:0] paddr;
  logic [7:0] pwdata;
  logic [7:0] prdata;
  logic       pready;
  logic       pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/timer_irq_arb.sv
// Combinational winner select over the enabled pending channels.
// Fixed priority (channel 0 highest) by default; TIMER_IRQ_RR_EN selects round-robin.
module timer_irq_arb
  import timer_irq_pkg::*;
#(
  parameter int NCH = NCH_DEFAULT
) (
  input  logic [NCH-1:0]  req,
`ifdef TIMER_IRQ_RR_EN
  input  logic [ID_W-1:0] last_id,
`endif
  output logic            valid,
  output logic [ID_W-1:0] id
);

`ifdef TIMER_IRQ_RR_EN
  logic [ID_W-1:0] idx;

  // Search starts one past the last grant; the id width wraps modulo NCH.
  always_comb begin
    // NOTE: every output gets a default first, so no path leaves it unassigned
    // and no latch is inferred.
    valid = 1'b0;
    id    = '0;
    idx   = '0;
    for (int k = 1; k <= NCH; k++) begin
      idx = last_id + ID_W'(k);
      if (!valid && req[idx]) begin
        valid = 1'b1;
        id    = idx;
      end
    end
  end
`else
  // Scan from the top down so the lowest requesting channel is the last write.
  always_comb begin
    valid = 1'b0;
    id    = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (req[i]) begin
        valid = 1'b1;
        id    = ID_W'(i);
      end
    end
  end
`endif

endmodule

// File: rtl/timer_irq_ctrl.sv
// Timer interrupt controller: edge-detected pending bits, mask/enable, single-level
// IDLE/REQ/SERVICE handshake with EOI. Define TIMER_IRQ_RR_EN for round-robin arbitration.
module timer_irq_ctrl
  import timer_irq_pkg::*;
#(
  parameter int NCH = NCH_DEFAULT
) (
  input  logic            pclk,
  input  logic            presetn,
  timer_irq_ctrl_if.slave apb,
  input  logic [NCH-1:0]  tmr_ovf,
  input  logic [NCH-1:0]  tmr_udf,
  output logic            irq,
  output logic [ID_W-1:0] irq_id,
  input  logic            irq_ack
);

  state_e          state_q, state_d;
  logic [NCH-1:0]  ipr_q, ipr_d;
  logic [NCH-1:0]  imr_q, imr_d;
  logic [NCH-1:0]  flag_q, flag_d;
  logic            icr_en_q, icr_en_d;
  logic            edge_arm_q;
  logic [ID_W-1:0] irq_id_q, irq_id_d;
  logic [NCH-1:0]  evt, w1c_mask, ack_clr;
  logic            access, wr_en, eoi_wr;
  logic            arb_valid;
  logic [ID_W-1:0] arb_id;

  assign access = apb.psel & apb.penable;
  assign wr_en  = access & apb.pwrite;
  assign eoi_wr = wr_en & (apb.paddr == ADDR_EOI);

  // The first clock after reset only loads the edge register, so flags already
  // high at release never count as an edge.
  assign flag_d = tmr_ovf | tmr_udf;
  assign evt    = edge_arm_q ? (flag_d & ~flag_q) : '0;

`ifdef TIMER_IRQ_RR_EN
  logic [ID_W-1:0] last_q, last_d;
`endif

  timer_irq_arb #(.NCH(NCH)) u_arb (
    .req     (ipr_q & imr_q),
`ifdef TIMER_IRQ_RR_EN
    .last_id (last_q),
`endif
    .valid   (arb_valid),
    .id      (arb_id)
  );

  // Register writes; a new event wins over a same-cycle W1C or ack clear.
  always_comb begin
    w1c_mask = '0;
    imr_d    = imr_q;
    icr_en_d = icr_en_q;
    if (wr_en) begin
      case (apb.paddr)
        ADDR_IPR: w1c_mask = apb.pwdata[NCH-1:0];
        ADDR_IMR: imr_d    = apb.pwdata[NCH-1:0];
        ADDR_ICR: icr_en_d = apb.pwdata[0];
        default:  ;
      endcase
    end
    ipr_d = (ipr_q & ~w1c_mask & ~ack_clr) | evt;
  end

  always_comb begin
    state_d  = state_q;
    irq_id_d = irq_id_q;
    ack_clr  = '0;
`ifdef TIMER_IRQ_RR_EN
    last_d   = last_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (icr_en_q && arb_valid) begin
          state_d  = ST_REQ;
          irq_id_d = arb_id;
        end
      end
      ST_REQ: begin
        if (irq_ack) begin
          state_d           = ST_SERVICE;
          ack_clr[irq_id_q] = 1'b1;
`ifdef TIMER_IRQ_RR_EN
          last_d            = irq_id_q;
`endif
        end else if (!ipr_q[irq_id_q] || !imr_q[irq_id_q] || !icr_en_q) begin
          state_d = ST_IDLE;
        end
      end
      ST_SERVICE: begin
        if (eoi_wr) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q    <= ST_IDLE;
      ipr_q      <= '0;
      imr_q      <= '0;
      icr_en_q   <= 1'b0;
      irq_id_q   <= '0;
      flag_q     <= '0;
      edge_arm_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments, so every flop samples pre-edge values
      // regardless of statement order.
      state_q    <= state_d;
      ipr_q      <= ipr_d;
      imr_q      <= imr_d;
      icr_en_q   <= icr_en_d;
      irq_id_q   <= irq_id_d;
      flag_q     <= flag_d;
      edge_arm_q <= 1'b1;
    end
  end

`ifdef TIMER_IRQ_RR_EN
  // Starting at NCH-1 makes channel 0 the first candidate after reset.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) last_q <= ID_W'(NCH - 1);
    else          last_q <= last_d;
  end
`endif

  always_comb begin
    apb.prdata = '0;
    if (access) begin
      case (apb.paddr)
        ADDR_IPR: apb.prdata = 8'(ipr_q);
        ADDR_IMR: apb.prdata = 8'(imr_q);
        ADDR_ISR: apb.prdata = {state_q == ST_SERVICE, 5'b0, irq_id_q};
        ADDR_ICR: apb.prdata = {7'b0, icr_en_q};
        default:  apb.prdata = '0;
      endcase
    end
  end

  assign apb.pready  = 1'b1;
  assign apb.pslverr = access & ~addr_mapped(apb.paddr);

  assign irq    = (state_q == ST_REQ);
  assign irq_id = irq_id_q;

endmodule

// File: tb/tb_timer_irq_ctrl.sv
// Self-checking bench for timer_irq_ctrl: directed scenarios plus randomized traffic
// compared against a cycle-level behavioural model of the register/handshake rules.
module tb_timer_irq_ctrl;

  logic       pclk;
  logic       presetn;
  logic [3:0] tmr_ovf;
  logic [3:0] tmr_udf;
  logic       irq;
  logic [1:0] irq_id;
  logic       irq_ack;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  timer_irq_ctrl_if apb ();

  timer_irq_ctrl #(.NCH(4)) dut (
    .pclk    (pclk),
    .presetn (presetn),
    .apb     (apb),
    .tmr_ovf (tmr_ovf),
    .tmr_udf (tmr_udf),
    .irq     (irq),
    .irq_id  (irq_id),
    .irq_ack (irq_ack)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  // Reference model state
  logic [3:0] m_ipr, m_imr, m_prev;
  bit         m_en, m_req, m_svc, m_armed;
  int         m_id;
`ifdef TIMER_IRQ_RR_EN
  int         m_last;
`endif

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // First candidate scanning upward from (last + 1) mod 4.
  function automatic int pick(input logic [3:0] cand, input int last);
    for (int k = 1; k <= 4; k++) begin
      if (cand[(last + k) % 4]) return (last + k) % 4;
    end
    return 0;
  endfunction

  function automatic logic [7:0] model_rd(input logic [7:0] a);
    case (a)
      8'h00:   return {4'b0, m_ipr};
      8'h01:   return {4'b0, m_imr};
      8'h02:   return {m_svc, 5'b0, 2'(m_id)};
      8'h03:   return {7'b0, m_en};
      default: return 8'h00;
    endcase
  endfunction

  task automatic model_reset();
    m_ipr = '0; m_imr = '0; m_prev = '0;
    m_en = 0; m_req = 0; m_svc = 0; m_armed = 0; m_id = 0;
`ifdef TIMER_IRQ_RR_EN
    m_last = 3;
`endif
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_step();
    logic [3:0] flags, evt, nxt_ipr;
    bit wr;
    flags   = tmr_ovf | tmr_udf;
    evt     = m_armed ? (flags & ~m_prev) : 4'b0;
    wr      = apb.psel && apb.penable && apb.pwrite;
    nxt_ipr = m_ipr;
    if (wr && apb.paddr == 8'h00) nxt_ipr = nxt_ipr & ~apb.pwdata[3:0];
    if (m_req) begin
      if (irq_ack) begin
        nxt_ipr[m_id] = 1'b0;
        m_req = 0;
        m_svc = 1;
`ifdef TIMER_IRQ_RR_EN
        m_last = m_id;
`endif
      end else if (!m_ipr[m_id] || !m_imr[m_id] || !m_en) begin
        m_req = 0;
      end
    end else if (m_svc) begin
      if (wr && apb.paddr == 8'h04) m_svc = 0;
    end else if (m_en && (m_ipr & m_imr) != 4'b0) begin
      m_req = 1;
`ifdef TIMER_IRQ_RR_EN
      m_id = pick(m_ipr & m_imr, m_last);
`else
      m_id = pick(m_ipr & m_imr, 3);
`endif
    end
    m_ipr = nxt_ipr | evt;
    if (wr && apb.paddr == 8'h01) m_imr = apb.pwdata[3:0];
    if (wr && apb.paddr == 8'h03) m_en  = apb.pwdata[0];
    m_prev  = flags;
    m_armed = 1;
  endtask

  task automatic tick();
    model_step();
    @(posedge pclk);
    #1;
  endtask

  task automatic apb_write(input logic [7:0] a, input logic [7:0] d);
    apb.psel = 1; apb.penable = 0; apb.pwrite = 1; apb.paddr = a; apb.pwdata = d;
    tick();
    apb.penable = 1;
    tick();
    apb.psel = 0; apb.penable = 0; apb.pwrite = 0;
  endtask

  task automatic apb_read(input logic [7:0] a, output logic [7:0] data, output logic err,
                          output logic [7:0] exp_data, output logic exp_err);
    apb.psel = 1; apb.penable = 0; apb.pwrite = 0; apb.paddr = a;
    tick();
    apb.penable = 1;
    #1;
    data     = apb.prdata;
    err      = apb.pslverr;
    exp_data = model_rd(a);
    exp_err  = (a > 8'h04);
    tick();
    apb.psel = 0; apb.penable = 0;
  endtask

  task automatic rd_check(input string tag, input logic [7:0] a, input logic [7:0] want);
    logic [7:0] d, ed;
    logic e, ee;
    apb_read(a, d, e, ed, ee);
    check(tag, d, want);
  endtask

  task automatic ack_and_eoi();
    irq_ack = 1; tick(); irq_ack = 0;
    apb_write(8'h04, 8'h00);
  endtask

  initial begin
    logic [7:0] d, ed;
    logic e, ee;
    int presc, tdr;
    bit uf;
    logic [1:0] first_id, second_id;

    presetn = 0; tmr_ovf = '0; tmr_udf = '0; irq_ack = 0;
    apb.psel = 0; apb.penable = 0; apb.pwrite = 0; apb.paddr = '0; apb.pwdata = '0;
    model_reset();

    // Reset state
    #2;
    apb.psel = 1; apb.penable = 1; apb.paddr = 8'h02;
    #1;
    check("rst_irq", irq, 0);
    check("rst_irq_id", irq_id, 0);
    check("rst_isr", apb.prdata, 8'h00);
    check("rst_pslverr", apb.pslverr, 0);
    apb.psel = 0; apb.penable = 0;
    #9 presetn = 1;
    model_reset();
    tick();

    // Single underflow on channel 2
    apb_write(8'h01, 8'h0F);
    apb_write(8'h03, 8'h01);
    tmr_udf = 4'b0100; tick(); tmr_udf = '0; tick();
    check("udf2_irq", irq, 1);
    check("udf2_id", irq_id, 2);
    rd_check("udf2_ipr", 8'h00, 8'h04);
    irq_ack = 1; tick(); irq_ack = 0;
    check("udf2_ack_irq", irq, 0);
    rd_check("udf2_ack_ipr", 8'h00, 8'h00);
    rd_check("udf2_isr", 8'h02, 8'h82);
    apb_write(8'h04, 8'h00);
    tick();
    check("udf2_eoi_irq", irq, 0);
    apb_read(8'h02, d, e, ed, ee);
    check("udf2_eoi_busy", d & 8'h80, 8'h00);

    // Grant channel 1 alone, then raise channels 1 and 3 together
    tmr_ovf = 4'b0010; tick(); tmr_ovf = '0; tick();
    check("ch1_id", irq_id, 1);
    ack_and_eoi();
`ifdef TIMER_IRQ_RR_EN
    first_id = 2'd3; second_id = 2'd1;
`else
    first_id = 2'd1; second_id = 2'd3;
`endif
    tmr_ovf = 4'b1010; tick(); tmr_ovf = '0; tick();
    check("arb_first_irq", irq, 1);
    check("arb_first_id", irq_id, first_id);
    ack_and_eoi();
    tick();
    check("arb_second_irq", irq, 1);
    check("arb_second_id", irq_id, second_id);
    ack_and_eoi();
    tick();

    // Masked event stays pending until unmasked
    apb_write(8'h01, 8'h00);
    tmr_ovf = 4'b0001; tick(); tmr_ovf = '0; tick(); tick();
    check("mask_irq", irq, 0);
    rd_check("mask_ipr", 8'h00, 8'h01);
    apb_write(8'h01, 8'h01);
    tick();
    check("unmask_irq", irq, 1);
    check("unmask_id", irq_id, 0);

    // W1C of the latched channel while requesting withdraws the request
    apb_write(8'h00, 8'h01);
    tick();
    check("w1c_abort_irq", irq, 0);
    apb_read(8'h02, d, e, ed, ee);
    check("w1c_abort_busy", d & 8'h80, 8'h00);

    // Same-cycle edge and W1C: set wins
    apb.psel = 1; apb.penable = 0; apb.pwrite = 1; apb.paddr = 8'h00; apb.pwdata = 8'h02;
    tick();
    apb.penable = 1; tmr_ovf = 4'b0010;
    tick();
    apb.psel = 0; apb.penable = 0; apb.pwrite = 0; tmr_ovf = '0;
    rd_check("set_wins_ipr", 8'h00, 8'h02);
    apb_write(8'h00, 8'h02);
    rd_check("w1c_clear_ipr", 8'h00, 8'h00);

    // Unmapped read, then async reset in SERVICE with a flag held high
    apb_read(8'h07, d, e, ed, ee);
    check("unmapped_err", e, 1);
    check("unmapped_data", d, 8'h00);
    tmr_ovf = 4'b0001; tick(); tmr_ovf = '0; tick();
    irq_ack = 1; tick(); irq_ack = 0;
    rd_check("svc_isr", 8'h02, 8'h80);
    tmr_udf = 4'b0001;
    #2 presetn = 0;
    #1;
    check("async_rst_irq", irq, 0);
    check("async_rst_id", irq_id, 0);
    apb.psel = 1; apb.penable = 1; apb.paddr = 8'h02;
    #1 check("async_rst_isr", apb.prdata, 8'h00);
    apb.paddr = 8'h01;
    #1 check("async_rst_imr", apb.prdata, 8'h00);
    apb.psel = 0; apb.penable = 0;
    @(negedge pclk);
    presetn = 1;
    model_reset();
    tick();
    rd_check("post_rst_imr", 8'h01, 8'h00);
    rd_check("post_rst_icr", 8'h03, 8'h00);
    apb_write(8'h01, 8'h01);
    apb_write(8'h03, 8'h01);
    tick();
    check("held_flag_irq", irq, 0);
    rd_check("held_flag_ipr", 8'h00, 8'h00);
    tmr_udf = '0; tick();

    // Prescaled countdown timer on channel 0: clk/4 from 0xFF
    presc = 0; tdr = 255; uf = 0;
    for (int c = 0; c < 1100; c++) begin
      tmr_udf[0] = uf;
      tick();
      if (c < 500 && c % 100 == 0) check("timer_quiet", irq, 0);
      presc++;
      if (presc == 4) begin
        presc = 0;
        if (tdr == 0) begin uf = 1; tdr = 255; end
        else tdr--;
      end
    end
    check("timer_irq", irq, 1);
    check("timer_id", irq_id, 0);
    rd_check("timer_ipr", 8'h00, 8'h01);
    tmr_udf = '0;
    ack_and_eoi();
    tick();

    // Randomized traffic against the model
    for (int n = 0; n < 200; n++) begin
      int op;
      op = $urandom_range(0, 9);
      if (op == 0) begin
        apb_write(8'($urandom_range(0, 5)), 8'($urandom));
      end else if (op == 1) begin
        apb_write(8'h04, 8'h00);
      end else if (op == 2) begin
        apb_read(8'($urandom_range(0, 7)), d, e, ed, ee);
        check("rnd_prdata", d, ed);
        check("rnd_pslverr", e, ee);
      end else begin
        tmr_ovf = 4'($urandom & $urandom);
        tmr_udf = 4'($urandom & $urandom);
        irq_ack = ($urandom_range(0, 3) == 0);
        tick();
        irq_ack = 0;
      end
      check("rnd_irq", irq, m_req);
      check("rnd_irq_id", irq_id, 2'(m_id));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/timer_irq_ctrl.md
TIMER_IRQ_CTRL -- requirements
Module: timer_irq_ctrl

Interface
REQ-001 Parameter NCH, default 4, number of timer channels serviced (fixed 4 in this revision, ids 2 bits).
REQ-002 pclk  in  1  APB/system clock; all logic on rising edge.
REQ-003 presetn  in  1  asynchronous active-low reset.
REQ-004 psel, penable, pwrite  in  1 each  APB control; zero-wait-state access phase.
REQ-005 paddr  in  8  register address; pwdata  in  8  write data.
REQ-006 prdata  out  8  read data; pready  out  1  tied 1; pslverr  out  1  high on access to an unmapped address.
REQ-007 tmr_ovf  in  NCH  per-channel timer overflow flag (TSR bit0 level).
REQ-008 tmr_udf  in  NCH  per-channel timer underflow flag (TSR bit1 level).
REQ-009 irq  out  1  interrupt request to CPU.
REQ-010 irq_id  out  2  channel currently requesting or in service.
REQ-011 irq_ack  in  1  single-cycle CPU acknowledge.

Function
REQ-012 Registers: 0x00 IPR pending (W1C), 0x01 IMR enable mask, 0x02 ISR in-service (RO, bit7 = busy, bits1:0 = id), 0x03 ICR (bit0 global enable), 0x04 EOI (WO, any write ends service); other addresses -> pslverr=1, prdata=0, no state change.
REQ-013 Pending bit n sets on a rising edge of (tmr_ovf[n] | tmr_udf[n]), detected against a registered copy, one cycle after the edge.
REQ-014 A set event and a W1C clear of the same bit in one cycle -> bit stays set.
REQ-015 FSM states IDLE, REQ, SERVICE.
REQ-016 IDLE -> REQ when ICR[0]=1 and (IPR & IMR) != 0; irq_id latched from arbitration winner; irq=1 the cycle after entry.
REQ-017 REQ -> SERVICE on irq_ack: irq=0 next cycle, winning IPR bit cleared, ISR busy set.
REQ-018 SERVICE -> IDLE on EOI write; ISR busy cleared; new request may issue one cycle later.
REQ-019 In REQ, clearing the latched bit via W1C, masking it, or ICR[0]=0 -> return to IDLE, irq=0, no ack required.
REQ-020 irq_id stable from REQ entry until IDLE return; irq_ack outside REQ ignored.
REQ-021 Default arbitration fixed priority, channel 0 highest.
REQ-022 No nesting: new pending events in SERVICE accumulate in IPR only.
REQ-023 Read latency zero: prdata valid in access phase (psel & penable).

Reset
REQ-024 presetn=0 -> IPR=0, IMR=0, ICR=0, ISR=0, FSM=IDLE, irq=0, irq_id=0, prdata=0, pslverr=0, edge registers=0.
REQ-025 Reset mid-REQ or mid-SERVICE drops irq asynchronously; flags high at release do not create events until a new rising edge.

Configuration
REQ-026 Macro TIMER_IRQ_RR_EN defined -> round-robin arbitration, search starts at (last granted id + 1) mod NCH; pointer resets to NCH-1 (channel 0 first).
REQ-027 Macro undefined -> fixed priority per REQ-021, no pointer register.

Structure
REQ-028 Shared package timer_irq_pkg: register address constants, FSM state enum, NCH default, id width.
REQ-029 One sub-module timer_irq_arb: combinational winner select from (IPR & IMR) plus optional round-robin pointer.

Verification
REQ-030 IMR=0x0F, ICR=0x01, pulse tmr_udf[2] -> IPR=0x04, irq=1, irq_id=2 within 2 cycles; ack -> irq=0, IPR=0x00, ISR=0x82.
REQ-031 Simultaneous tmr_ovf[1] and tmr_ovf[3] edges -> irq_id=1; after ack+EOI, irq_id=3 (fixed); with TIMER_IRQ_RR_EN after previous grant 1, grant order 3 then 1.
REQ-032 IMR=0x00 and flag edge -> IPR bit set, irq stays 0; write IMR=0x01 -> irq=1 next cycle.
REQ-033 In REQ write IPR=0x01 (W1C) on the latched channel -> irq=0, FSM IDLE; same-cycle edge and W1C -> IPR bit remains 1.
REQ-034 Read 0x07 -> pslverr=1, prdata=0x00; assert presetn low during SERVICE -> irq=0, all registers 0 immediately.
REQ-035 Timer countdown, clk/4, TDR=0xFF, underflow at ~1024 pclk -> IPR[0]=1 and irq=1; no event before 500 pclk.
